// File: rtl/light_pkg.sv
// Shared types for the intersection light sequencer: phase encoding and lamp patterns.
`timescale 1ns/1ps
package light_pkg;

    typedef enum logic [2:0] {
        MAIN_GRN = 3'd0,
        MAIN_EXT = 3'd1,
        MAIN_YEL = 3'd2,
        WALK     = 3'd3,
        SIDE_GRN = 3'd4,
        SIDE_EXT = 3'd5,
        SIDE_YEL = 3'd6
    } state_t;

    // Lamp patterns are {red, yellow, green}, one-hot.
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    localparam int TIMER_W = 4;

endpackage

// File: rtl/tick_gen.sv
// One-second tick prescaler: free-running counter 0..TICK_DIV-1, tick decoded on the last count.
`timescale 1ns/1ps
module tick_gen #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    always_comb begin
        count_next = count_reg + CW'(1);
        if (count_reg == LAST) begin
            count_next = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign tick = (count_reg == LAST);

endmodule

// File: rtl/light_sequencer.sv
// Intersection phase controller: tick-timed ring of main/side phases with sensor extension.
// LIGHT_WALK_EN enables the latched pedestrian request and the all-red WALK phase.
`timescale 1ns/1ps
import light_pkg::*;

module light_sequencer #(
    parameter int TICK_DIV = 100_000_000,
    parameter int T_BASE   = 6,
    parameter int T_EXT    = 3,
    parameter int T_YEL    = 2,
    parameter int T_WALK   = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       walk,
    input  logic       sensor,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk_lamp,
    output logic       tick
);

    localparam logic [TIMER_W-1:0] LAST_BASE = TIMER_W'(T_BASE - 1);
    localparam logic [TIMER_W-1:0] LAST_EXT  = TIMER_W'(T_EXT - 1);
    localparam logic [TIMER_W-1:0] LAST_YEL  = TIMER_W'(T_YEL - 1);
    localparam logic [TIMER_W-1:0] LAST_WALK = TIMER_W'(T_WALK - 1);

    state_t               state_reg;
    state_t               state_next;
    logic [TIMER_W-1:0]   timer_reg;
    logic [TIMER_W-1:0]   timer_next;
    logic [TIMER_W-1:0]   last_tick;
    logic                 expire;
    logic                 state_change;
    logic                 ext_flag_reg;
    logic                 ext_flag_next;
    logic                 walk_go;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

`ifdef LIGHT_WALK_EN
    logic walk_pending_reg;
    logic walk_pending_next;

    // Entering WALK serves the request, so the clear beats a same-cycle request.
    always_comb begin
        walk_pending_next = walk_pending_reg | walk;
        if (state_change && (state_next == WALK)) begin
            walk_pending_next = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            walk_pending_reg <= 1'b0;
        end else begin
            walk_pending_reg <= walk_pending_next;
        end
    end

    assign walk_go   = walk_pending_reg;
    assign walk_lamp = (state_reg == WALK);
`else
    logic walk_unused;

    assign walk_unused = walk;
    assign walk_go     = 1'b0;
    assign walk_lamp   = 1'b0;
`endif

    always_comb begin
        last_tick = LAST_BASE;
        case (state_reg)
            MAIN_GRN, SIDE_GRN: last_tick = LAST_BASE;
            MAIN_EXT, SIDE_EXT: last_tick = LAST_EXT;
            MAIN_YEL, SIDE_YEL: last_tick = LAST_YEL;
            WALK:               last_tick = LAST_WALK;
            default:            last_tick = LAST_BASE;
        endcase
    end

    assign expire = tick && (timer_reg == last_tick);

    // A sensor hit on the expiry cycle itself still counts toward the main extension.
    always_comb begin
        state_next = state_reg;
        if (expire) begin
            case (state_reg)
                MAIN_GRN: state_next = (ext_flag_reg || sensor) ? MAIN_EXT : MAIN_YEL;
                MAIN_EXT: state_next = MAIN_YEL;
                MAIN_YEL: state_next = walk_go ? WALK : SIDE_GRN;
                WALK:     state_next = SIDE_GRN;
                SIDE_GRN: state_next = sensor ? SIDE_EXT : SIDE_YEL;
                SIDE_EXT: state_next = SIDE_YEL;
                SIDE_YEL: state_next = MAIN_GRN;
                default:  state_next = MAIN_GRN;
            endcase
        end
    end

    assign state_change = (state_next != state_reg);

    always_comb begin
        timer_next = timer_reg;
        if (state_change) begin
            timer_next = '0;
        end else if (tick) begin
            timer_next = timer_reg + TIMER_W'(1);
        end
    end

    always_comb begin
        ext_flag_next = 1'b0;
        if ((state_reg == MAIN_GRN) && !state_change) begin
            ext_flag_next = ext_flag_reg | sensor;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg    <= MAIN_GRN;
            timer_reg    <= '0;
            ext_flag_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            timer_reg    <= timer_next;
            ext_flag_reg <= ext_flag_next;
        end
    end

    always_comb begin
        main_light = RED;
        side_light = RED;
        case (state_reg)
            MAIN_GRN, MAIN_EXT: main_light = GRN;
            MAIN_YEL:           main_light = YEL;
            SIDE_GRN, SIDE_EXT: side_light = GRN;
            SIDE_YEL:           side_light = YEL;
            default: begin
                main_light = RED;
                side_light = RED;
            end
        endcase
    end

endmodule

// File: tb/tb_light_sequencer.sv
// Directed bench for light_sequencer: measures each lit phase in cycles and compares to hand-computed lengths.
`timescale 1ns/1ps
module tb_light_sequencer;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    typedef struct {
        logic [2:0] m;
        logic [2:0] s;
        logic       lamp;
        int         len;
    } phase_t;

    logic       clock  = 1'b0;
    logic       reset  = 1'b0;
    logic       walk   = 1'b0;
    logic       sensor = 1'b0;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk_lamp;
    logic       tick;

    int checks = 0;
    int fails  = 0;

    light_sequencer #(
        .TICK_DIV (4),
        .T_BASE   (6),
        .T_EXT    (3),
        .T_YEL    (2),
        .T_WALK   (3)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .walk       (walk),
        .sensor     (sensor),
        .main_light (main_light),
        .side_light (side_light),
        .walk_lamp  (walk_lamp),
        .tick       (tick)
    );

    always #5 clock = ~clock;

    function automatic phase_t ph(input logic [2:0] m, input logic [2:0] s,
                                  input logic lamp, input int len);
        phase_t p;
        p.m    = m;
        p.s    = s;
        p.lamp = lamp;
        p.len  = len;
        return p;
    endfunction

    // Release lands on a falling edge; that sample is cycle 0 of the first MAIN_GRN.
    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    // Count falling-edge samples until any output changes; bounded so a stuck DUT cannot hang.
    task automatic measure_phase(output logic [2:0] m, output logic [2:0] s,
                                 output logic l, output int len);
        m   = main_light;
        s   = side_light;
        l   = walk_lamp;
        len = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (main_light !== m || side_light !== s || walk_lamp !== l) break;
            len++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (main_light !== G || side_light !== R || walk_lamp !== 1'b0 || tick !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: got main=%b side=%b lamp=%b tick=%b, want 001 100 0 0",
                     main_light, side_light, walk_lamp, tick);
        end else begin
            $display("ok reset_state: main=%b side=%b lamp=%b tick=%b", main_light, side_light, walk_lamp, tick);
        end
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (tick !== ((k % 4) == 3) || main_light !== G || side_light !== R) begin
                fails++;
                $display("FAIL tick_cycle%0d: got tick=%b main=%b side=%b, want tick=%b main=001 side=100",
                         k, tick, main_light, side_light, ((k % 4) == 3));
            end else begin
                $display("ok tick_cycle%0d: tick=%b", k, tick);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_ring();
        phase_t     exp_q[$];
        logic [2:0] m, s;
        logic       l;
        int         n;
        exp_q.push_back(ph(G, R, 1'b0, 24));
        exp_q.push_back(ph(Y, R, 1'b0, 8));
        exp_q.push_back(ph(R, G, 1'b0, 24));
        exp_q.push_back(ph(R, Y, 1'b0, 8));
        exp_q.push_back(ph(G, R, 1'b0, 24));
        do_reset();
        for (int i = 0; i < exp_q.size(); i++) begin
            measure_phase(m, s, l, n);
            checks++;
            if (m !== exp_q[i].m || s !== exp_q[i].s || l !== exp_q[i].lamp || n !== exp_q[i].len) begin
                fails++;
                $display("FAIL ring_phase%0d: got main=%b side=%b lamp=%b len=%0d, want main=%b side=%b lamp=%b len=%0d",
                         i, m, s, l, n, exp_q[i].m, exp_q[i].s, exp_q[i].lamp, exp_q[i].len);
            end else begin
                $display("ok ring_phase%0d: main=%b side=%b lamp=%b len=%0d", i, m, s, l, n);
            end
        end
    endtask

    // Sensor pulse at cycle 5 of MAIN_GRN: green lasts 24+12 cycles, measured from cycle 6.
    task automatic test_main_ext();
        phase_t     exp_q[$];
        logic [2:0] m, s;
        logic       l;
        int         n;
        exp_q.push_back(ph(G, R, 1'b0, 30));
        exp_q.push_back(ph(Y, R, 1'b0, 8));
        exp_q.push_back(ph(R, G, 1'b0, 24));
        exp_q.push_back(ph(R, Y, 1'b0, 8));
        exp_q.push_back(ph(G, R, 1'b0, 24));
        exp_q.push_back(ph(Y, R, 1'b0, 8));
        do_reset();
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i == 0) begin
                repeat (5) @(negedge clock);
                sensor = 1'b1;
                @(negedge clock);
                sensor = 1'b0;
            end
            measure_phase(m, s, l, n);
            checks++;
            if (m !== exp_q[i].m || s !== exp_q[i].s || l !== exp_q[i].lamp || n !== exp_q[i].len) begin
                fails++;
                $display("FAIL main_ext_phase%0d: got main=%b side=%b lamp=%b len=%0d, want main=%b side=%b lamp=%b len=%0d",
                         i, m, s, l, n, exp_q[i].m, exp_q[i].s, exp_q[i].lamp, exp_q[i].len);
            end else begin
                $display("ok main_ext_phase%0d: main=%b side=%b lamp=%b len=%0d", i, m, s, l, n);
            end
        end
    endtask

    // Walk pulse at cycle 5 of SIDE_GRN is served after the following MAIN_YEL.
    task automatic test_walk();
        phase_t     exp_q[$];
        logic [2:0] m, s;
        logic       l;
        int         n;
        exp_q.push_back(ph(G, R, 1'b0, 24));
        exp_q.push_back(ph(Y, R, 1'b0, 8));
        exp_q.push_back(ph(R, G, 1'b0, 18));
        exp_q.push_back(ph(R, Y, 1'b0, 8));
        exp_q.push_back(ph(G, R, 1'b0, 24));
        exp_q.push_back(ph(Y, R, 1'b0, 8));
`ifdef LIGHT_WALK_EN
        exp_q.push_back(ph(R, R, 1'b1, 12));
`endif
        exp_q.push_back(ph(R, G, 1'b0, 24));
        exp_q.push_back(ph(R, Y, 1'b0, 8));
        exp_q.push_back(ph(G, R, 1'b0, 24));
        exp_q.push_back(ph(Y, R, 1'b0, 8));
        exp_q.push_back(ph(R, G, 1'b0, 24));
        do_reset();
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i == 2) begin
                repeat (5) @(negedge clock);
                walk = 1'b1;
                @(negedge clock);
                walk = 1'b0;
            end
            measure_phase(m, s, l, n);
            checks++;
            if (m !== exp_q[i].m || s !== exp_q[i].s || l !== exp_q[i].lamp || n !== exp_q[i].len) begin
                fails++;
                $display("FAIL walk_phase%0d: got main=%b side=%b lamp=%b len=%0d, want main=%b side=%b lamp=%b len=%0d",
                         i, m, s, l, n, exp_q[i].m, exp_q[i].s, exp_q[i].lamp, exp_q[i].len);
            end else begin
                $display("ok walk_phase%0d: main=%b side=%b lamp=%b len=%0d", i, m, s, l, n);
            end
        end
    endtask

    // Sensor held across the first SIDE_GRN expiry only; the second SIDE_GRN sees it low.
    task automatic test_side_ext();
        phase_t     exp_q[$];
        logic [2:0] m, s;
        logic       l;
        int         n;
        exp_q.push_back(ph(G, R, 1'b0, 24));
        exp_q.push_back(ph(Y, R, 1'b0, 8));
        exp_q.push_back(ph(R, G, 1'b0, 36));
        exp_q.push_back(ph(R, Y, 1'b0, 8));
        exp_q.push_back(ph(G, R, 1'b0, 24));
        exp_q.push_back(ph(Y, R, 1'b0, 8));
        exp_q.push_back(ph(R, G, 1'b0, 24));
        exp_q.push_back(ph(R, Y, 1'b0, 8));
        do_reset();
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i == 2) sensor = 1'b1;
            if (i == 3) sensor = 1'b0;
            measure_phase(m, s, l, n);
            checks++;
            if (m !== exp_q[i].m || s !== exp_q[i].s || l !== exp_q[i].lamp || n !== exp_q[i].len) begin
                fails++;
                $display("FAIL side_ext_phase%0d: got main=%b side=%b lamp=%b len=%0d, want main=%b side=%b lamp=%b len=%0d",
                         i, m, s, l, n, exp_q[i].m, exp_q[i].s, exp_q[i].lamp, exp_q[i].len);
            end else begin
                $display("ok side_ext_phase%0d: main=%b side=%b lamp=%b len=%0d", i, m, s, l, n);
            end
        end
    endtask

    // A second walk request made during WALK must be discarded by a mid-cycle reset.
    task automatic test_async_reset();
        phase_t     exp_q[$];
        logic [2:0] m, s;
        logic       l;
        int         n;
        do_reset();
        repeat (2) @(negedge clock);
        walk = 1'b1;
        @(negedge clock);
        walk = 1'b0;
        exp_q.push_back(ph(G, R, 1'b0, 21));
        exp_q.push_back(ph(Y, R, 1'b0, 8));
        for (int i = 0; i < exp_q.size(); i++) begin
            measure_phase(m, s, l, n);
            checks++;
            if (m !== exp_q[i].m || s !== exp_q[i].s || l !== exp_q[i].lamp || n !== exp_q[i].len) begin
                fails++;
                $display("FAIL pre_reset_phase%0d: got main=%b side=%b lamp=%b len=%0d, want main=%b side=%b lamp=%b len=%0d",
                         i, m, s, l, n, exp_q[i].m, exp_q[i].s, exp_q[i].lamp, exp_q[i].len);
            end else begin
                $display("ok pre_reset_phase%0d: main=%b side=%b lamp=%b len=%0d", i, m, s, l, n);
            end
        end
        checks++;
`ifdef LIGHT_WALK_EN
        if (main_light !== R || side_light !== R || walk_lamp !== 1'b1) begin
            fails++;
            $display("FAIL walk_entered: got main=%b side=%b lamp=%b, want 100 100 1", main_light, side_light, walk_lamp);
        end else begin
            $display("ok walk_entered: main=%b side=%b lamp=%b", main_light, side_light, walk_lamp);
        end
`else
        if (main_light !== R || side_light !== G || walk_lamp !== 1'b0) begin
            fails++;
            $display("FAIL side_entered: got main=%b side=%b lamp=%b, want 100 001 0", main_light, side_light, walk_lamp);
        end else begin
            $display("ok side_entered: main=%b side=%b lamp=%b", main_light, side_light, walk_lamp);
        end
`endif
        @(negedge clock);
        walk = 1'b1;
        @(negedge clock);
        walk = 1'b0;
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (main_light !== G || side_light !== R || walk_lamp !== 1'b0 || tick !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: got main=%b side=%b lamp=%b tick=%b, want 001 100 0 0",
                     main_light, side_light, walk_lamp, tick);
        end else begin
            $display("ok async_reset: main=%b side=%b lamp=%b tick=%b", main_light, side_light, walk_lamp, tick);
        end
        @(negedge clock);
        reset = 1'b1;
        exp_q.delete();
        exp_q.push_back(ph(G, R, 1'b0, 24));
        exp_q.push_back(ph(Y, R, 1'b0, 8));
        exp_q.push_back(ph(R, G, 1'b0, 24));
        for (int i = 0; i < exp_q.size(); i++) begin
            measure_phase(m, s, l, n);
            checks++;
            if (m !== exp_q[i].m || s !== exp_q[i].s || l !== exp_q[i].lamp || n !== exp_q[i].len) begin
                fails++;
                $display("FAIL post_reset_phase%0d: got main=%b side=%b lamp=%b len=%0d, want main=%b side=%b lamp=%b len=%0d",
                         i, m, s, l, n, exp_q[i].m, exp_q[i].s, exp_q[i].lamp, exp_q[i].len);
            end else begin
                $display("ok post_reset_phase%0d: main=%b side=%b lamp=%b len=%0d", i, m, s, l, n);
            end
        end
    endtask

    // Walk held high from reset: ignored without the walk feature, served every ring with it.
    task automatic test_walk_held();
        phase_t     exp_q[$];
        logic [2:0] m, s;
        logic       l;
        int         n;
        exp_q.push_back(ph(G, R, 1'b0, 24));
        exp_q.push_back(ph(Y, R, 1'b0, 8));
`ifdef LIGHT_WALK_EN
        exp_q.push_back(ph(R, R, 1'b1, 12));
`endif
        exp_q.push_back(ph(R, G, 1'b0, 24));
        exp_q.push_back(ph(R, Y, 1'b0, 8));
        exp_q.push_back(ph(G, R, 1'b0, 24));
        walk = 1'b1;
        do_reset();
        for (int i = 0; i < exp_q.size(); i++) begin
            measure_phase(m, s, l, n);
            checks++;
            if (m !== exp_q[i].m || s !== exp_q[i].s || l !== exp_q[i].lamp || n !== exp_q[i].len) begin
                fails++;
                $display("FAIL walk_held_phase%0d: got main=%b side=%b lamp=%b len=%0d, want main=%b side=%b lamp=%b len=%0d",
                         i, m, s, l, n, exp_q[i].m, exp_q[i].s, exp_q[i].lamp, exp_q[i].len);
            end else begin
                $display("ok walk_held_phase%0d: main=%b side=%b lamp=%b len=%0d", i, m, s, l, n);
            end
        end
        walk = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ring();
        test_main_ext();
        test_walk();
        test_side_ext();
        test_async_reset();
        test_walk_held();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/light_sequencer.md
# light_sequencer

Phase controller for the intersection traffic-light datapath. It divides the system clock into a one-second tick, then sequences the main-street lights, side-street lights and pedestrian walk lamp through a fixed phase ring. A latched walk request inserts an all-red walk phase, and the vehicle sensor extends green phases. It sits directly under the lab top level, driving the board LEDs that `traffic_light` exposes.

## Interface
- `TICK_DIV`, 100_000_000, clock cycles per tick (≥2); the bench uses 4.
- `T_BASE`, 6, base green duration in ticks (1..15).
- `T_EXT`, 3, green extension in ticks (1..15).
- `T_YEL`, 2, yellow duration in ticks (1..15).
- `T_WALK`, 3, walk phase duration in ticks (1..15).
- `clock` in 1: system clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low; low forces reset state immediately, release is synchronous to `clock`.
- `walk` in 1: pedestrian request, level or pulse, ≥1 cycle.
- `sensor` in 1: side-street vehicle present.
- `main_light` out 3: {red,yellow,green}, one-hot.
- `side_light` out 3: {red,yellow,green}, one-hot.
- `walk_lamp` out 1: high only in WALK.
- `tick` out 1: one-cycle pulse per second, for debug and the bench.

## Operation
- States: MAIN_GRN, MAIN_EXT, MAIN_YEL, WALK, SIDE_GRN, SIDE_EXT, SIDE_YEL.
- Moore outputs are decoded from the state register. Side is red in MAIN_* and WALK; main is red in SIDE_* and WALK.
- The state timer counts ticks in the current state. The state exits on the tick where timer == duration-1, and the timer clears on every state change.
- MAIN_GRN (T_BASE): `sensor` high on any cycle in MAIN_GRN sets `ext_flag`. At expiry it goes to MAIN_EXT if `ext_flag` is set, otherwise MAIN_YEL. `ext_flag` clears on leaving MAIN_GRN.
- MAIN_EXT (T_EXT) → MAIN_YEL. The extension happens at most once per cycle.
- MAIN_YEL (T_YEL) → WALK if `walk_pending`, otherwise SIDE_GRN.
- WALK (T_WALK) → SIDE_GRN. `walk_pending` clears on entry to WALK.
- SIDE_GRN (T_BASE) → SIDE_EXT if `sensor` is high on the expiry cycle, otherwise SIDE_YEL.
- SIDE_EXT (T_EXT) → SIDE_YEL. SIDE_YEL (T_YEL) → MAIN_GRN.
- `walk_pending` sets on any cycle with `walk` high. If `walk` and entry to WALK occur in the same cycle, the clear wins: the request is already being served.

## Timing
- Reset values:
  - state MAIN_GRN, so `main_light`=3'b001 and `side_light`=3'b100.
  - `walk_lamp`=0, `tick`=0.
  - Prescaler, timer, `ext_flag` and `walk_pending` all 0.
- Prescaler counts 0..TICK_DIV-1 and wraps. `tick` is high in the cycle where the count equals TICK_DIV-1, so the first tick comes TICK_DIV cycles after reset release.
- The state register updates on the clock edge ending the expiry tick cycle. Outputs change in the following cycle, with no extra latency.
- Inputs are treated as synchronous; board-level synchronizers live in the top level.
- Reset asserted mid-phase returns to MAIN_GRN asynchronously and discards a pending walk.
- Widths: prescaler is $clog2(TICK_DIV) bits; timer is 4 bits. Durations outside 1..15 are unsupported.

## Configuration
- `LIGHT_WALK_EN` defined: walk latch, WALK state and `walk_lamp` behave as above.
- `LIGHT_WALK_EN` undefined:
  - `walk` is ignored and the latch is removed.
  - MAIN_YEL always goes to SIDE_GRN.
  - `walk_lamp` is tied to 0 and the WALK encoding is unused.

## Structure
- Package `light_pkg` holds:
  - the state enum typedef;
  - localparam light encodings RED=3'b100, YEL=3'b010, GRN=3'b001.
- Sub-module `tick_gen` holds the prescaler: parameter TICK_DIV, ports `clock`, `reset`, `tick`.
- The FSM, timer, latches and output decode stay in `light_sequencer`.

## Test plan
All scenarios use TICK_DIV=4 and default durations.
- Reset, no inputs:
  - MAIN_GRN for 24 cycles after release, then MAIN_YEL for 8, then SIDE_GRN for 24, SIDE_YEL for 8, back to MAIN_GRN.
  - `walk_lamp` stays 0 throughout.
- `sensor` pulsed 1 cycle mid MAIN_GRN → MAIN_EXT for 12 cycles before MAIN_YEL. Next MAIN_GRN with no sensor has no extension.
- `walk` pulsed 1 cycle during SIDE_GRN → after the next MAIN_YEL: WALK for 12 cycles with `walk_lamp`=1 and both lights red, then SIDE_GRN. The following ring has no WALK.
- `sensor` held high through the SIDE_GRN expiry → SIDE_EXT for 12 cycles. Sensor low at expiry → direct SIDE_YEL.
- `reset` low during WALK, mid-clock → outputs return to 3'b001/3'b100 and `walk_lamp`=0 without waiting for a clock edge. After release no WALK occurs.
- With `LIGHT_WALK_EN` undefined, `walk` held high → ring identical to scenario 1.
